// File: rtl/exit_pair_scheduler.sv
// exit_pair_scheduler: round-robin drain of per-cell outputs into the pair exit FIFO.
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   i_start / i_stop        drain sequencing pulses (IDLE->RUN, RUN->FLUSH)
//   i_cell_valid/i_cell_data per-cell elements; o_cell_ack pops the granted cells
//   i_fifo_afull            exit FIFO has at most one free slot
//   o_fifo_wr/o_fifo_data/o_pair_idx  registered FIFO write of the granted pair
//   o_busy, o_done, o_elem_count      drain status
module exit_pair_scheduler #(
  parameter int N_CELL     = 27,
  parameter int ELEM_WIDTH = 97
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [N_CELL-1:0]            i_cell_valid,
  input  logic [ELEM_WIDTH*N_CELL-1:0] i_cell_data,
  output logic [N_CELL-1:0]            o_cell_ack,
  input  logic                         i_fifo_afull,
  output logic                         o_fifo_wr,
  output logic [2*ELEM_WIDTH+1:0]      o_fifo_data,
  output logic [3:0]                   o_pair_idx,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [31:0]                  o_elem_count
);
  localparam int NPAIR = (N_CELL + 1) / 2;
  localparam int E = ELEM_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
  state_e state_q, state_d;
  logic [3:0] ptr_q, ptr_d, pidx_q, g;
  logic [31:0] count_q, count_d;
  logic wr_q, gnt, lo_v, hi_v;
  logic [2*E+1:0] data_q, data_d;
  logic [E-1:0] lo_d, hi_d;
  logic [NPAIR-1:0] req;
  int s;
  always_comb begin
    req = '0;
    for (int c = 0; c < N_CELL; c++) req[c/2] = req[c/2] | i_cell_valid[c];
  end
  // Scan from farthest to nearest so the pair closest to ptr is the last to win.
  always_comb begin
    g = '0;
    s = 0;
    gnt = 1'b0;
    for (int k = NPAIR - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      s = s >= NPAIR ? s - NPAIR : s;
      if (req[s]) begin
        g = 4'(s);
        gnt = 1'b1;
      end
    end
    gnt = gnt && (state_q == RUN || state_q == FLUSH) && !i_fifo_afull;
  end
  // Cells past N_CELL never match, so the pad hi lane of the last pair stays zero.
  always_comb begin
    lo_v = 1'b0;
    hi_v = 1'b0;
    lo_d = '0;
    hi_d = '0;
    o_cell_ack = '0;
    for (int c = 0; c < N_CELL; c++)
      if (gnt && 4'(c / 2) == g) begin
        o_cell_ack[c] = i_cell_valid[c];
        if (c % 2 == 0) begin
          lo_v = i_cell_valid[c];
          lo_d = i_cell_valid[c] ? i_cell_data[c*E +: E] : '0;
        end else begin
          hi_v = i_cell_valid[c];
          hi_d = i_cell_valid[c] ? i_cell_data[c*E +: E] : '0;
        end
      end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = gnt ? (g == 4'(NPAIR - 1) ? 4'd0 : g + 4'd1) : ptr_q;
    count_d = count_q + 32'(lo_v) + 32'(hi_v);
    data_d = {hi_v, lo_v, hi_d, lo_d};
    case (state_q)
      IDLE: if (i_start) begin
        state_d = RUN;
        ptr_d = '0;
        count_d = '0;
      end
      RUN: if (i_stop) state_d = FLUSH;
      // wr_q is the write still in flight from last cycle's grant.
      FLUSH: if (req == '0 && !wr_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk)
    if (!ap_rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      count_q <= '0;
      wr_q <= 1'b0;
      data_q <= '0;
      pidx_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
      wr_q <= gnt;
      data_q <= data_d;
      pidx_q <= gnt ? g : 4'd0;
    end
  assign o_fifo_wr = wr_q;
  assign o_fifo_data = data_q;
  assign o_pair_idx = pidx_q;
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  assign o_elem_count = count_q;
endmodule
